imem_loader: RTL and testbench

Boot-time program loader for the single-cycle RV32I core. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them into the instruction memory. Zero-fills the unused words and holds the core in reset until the image is complete.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_packer.sv | 41 ++++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state type, length limits and constants for imem_loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        CLEAR,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned LEN_MIN   = 1;
    localparam int unsigned DEPTH_MAX = 256;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // A length byte is usable when it names at least one word and fits the memory.
    function automatic logic len_ok(input logic [7:0] n, input int unsigned depth);
        return (32'(n) >= LEN_MIN) && (32'(n) <= depth) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// rtl/imem_loader_packer.sv - byte_packer: little-endian assembly of four accepted bytes into a word
module byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q,  sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_i, sr_q[23:8]};
        end
    end

    // The three buffered bytes plus the live fourth byte form the word, so it is ready on the accept.
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, sr_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming an RV32I image into instruction memory
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int              IDX_W     = ADDR_W + 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              accept;
    logic              word_valid;
    logic [31:0]       word;

    assign byte_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
    assign accept     = byte_valid && byte_ready;

    byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (state_q != DATA),
        .byte_valid_i (accept),
        .byte_i       (byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = LEN;
            end
            LEN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d = '0;
`endif
                if (accept) begin
                    if (len_ok(byte_data, DEPTH)) begin
                        state_d = DATA;
                        idx_d   = '0;
                        len_d   = IDX_W'(byte_data);
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) csum_d = csum_q ^ byte_data;
`endif
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_W-1:0];
                    wdata_d = word;
                    idx_d   = idx_q + ONE_IDX;
                    if (idx_q == len_q - ONE_IDX) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = CLEAR;
`endif
                    end
                end
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) state_d = (byte_data == csum_q) ? CLEAR : ERR;
`else
                state_d = ERR;
`endif
            end
            CLEAR: begin
                // A full image leaves nothing to zero; one idle CLEAR cycle keeps DONE timing uniform.
                if (idx_q == DEPTH_IDX) begin
                    state_d = DONE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_W-1:0];
                    wdata_d = ZERO_WORD;
                    idx_d   = idx_q + ONE_IDX;
                    if (idx_q == DEPTH_IDX - ONE_IDX) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == LEN) || (state_q == DATA) || (state_q == CHK) || (state_q == CLEAR);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign cpu_reset = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data  = 8'h00;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] obs_mem [DEPTH] = '{default: 32'hdead_beef};
    logic [31:0] ref_mem [DEPTH] = '{default: 32'hdead_beef};
    int          wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          acc_cyc_q [$];
    logic [7:0]  tx_q      [$];
    logic [31:0] img_q     [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    // Memory-side monitor: models the instruction RAM and logs every write with its cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_mem_we"},     mem_we,     0);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_mem_wdata"},  mem_wdata,  0);
        check({tag, "_cpu_reset"},  cpu_reset,  1);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_error"},      error,      0);
    endtask

    task automatic rand_image(input int n);
        img_q.delete();
        for (int w = 0; w < n; w++) img_q.push_back($urandom);
    endtask

    task automatic build_stream(input int n);
        logic [7:0] x;
        x = 8'h00;
        tx_q.delete();
        tx_q.push_back(8'(n));
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                tx_q.push_back(img_q[w][8*b +: 8]);
                x = x ^ img_q[w][8*b +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_bytes(input int count, input bit gaps, input bit poke);
        int g;
        bit expired;
        expired = 1'b0;
        acc_cyc_q.delete();
        for (int i = 0; i < count; i++) begin
            byte_data  = tx_q[i];
            byte_valid = 1'b1;
            if (poke && i == 2) start = 1'b1;
            g = 0;
            while (byte_ready !== 1'b1 && g < 50) begin
                step();
                g++;
            end
            if (g >= 50) expired = 1'b1;
            step();
            acc_cyc_q.push_back(cyc);
            start      = 1'b0;
            byte_valid = 1'b0;
            if (gaps) begin
                byte_data = 8'($urandom);
                step();
            end
        end
        check("byte_accept_wait", 32'(expired), 0);
    endtask

    task automatic run_load(input int n, input bit gaps, input bit poke);
        int g, last_acc, exp_done, exp_cyc;
        build_stream(n);
        pulse_start();
        check("start_busy",      busy,       1);
        check("start_ready",     byte_ready, 1);
        check("start_done_clr",  done,       0);
        check("start_error_clr", error,      0);
        check("start_cpu_reset", cpu_reset,  1);
        clear_log();
        send_bytes(tx_q.size(), gaps, poke);
        last_acc = acc_cyc_q[$];
        g = 0;
        while (done !== 1'b1 && error !== 1'b1 && g < 200) begin
            step();
            g++;
        end
        exp_done = last_acc + ((n < DEPTH) ? (DEPTH - n) : 1);
        check("done_cycle",      cyc,       exp_done);
        check("done",            done,      1);
        check("error",           error,     0);
        check("cpu_reset_done",  cpu_reset, 0);
        check("busy_done",       busy,      0);
        check("we_at_done",      mem_we,    (n < DEPTH) ? 1 : 0);
        if (n < DEPTH) check("addr_at_done", mem_addr, DEPTH - 1);
        step();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < n) ? img_q[i] : 32'h0;
        check("write_count", wr_addr_q.size(), DEPTH);
        if (!gaps) check("no_bubbles", acc_cyc_q[$] - acc_cyc_q[0], tx_q.size() - 1);
        for (int i = 0; i < DEPTH && i < wr_addr_q.size(); i++) begin
            exp_cyc = (i < n) ? acc_cyc_q[4*i + 4] : last_acc + 1 + (i - n);
            check("write_addr",  wr_addr_q[i], i);
            check("write_data",  wr_data_q[i], ref_mem[i]);
            check("write_cycle", wr_cyc_q[i],  exp_cyc);
        end
        for (int i = 0; i < DEPTH; i++) check("mem_word", obs_mem[i], ref_mem[i]);
    endtask

    task automatic run_bad_len(input logic [7:0] len);
        tx_q.delete();
        tx_q.push_back(len);
        pulse_start();
        clear_log();
        send_bytes(1, 1'b0, 1'b0);
        step();
        step();
        check("bad_len_error",     error,            1);
        check("bad_len_done",      done,             0);
        check("bad_len_cpu_reset", cpu_reset,        1);
        check("bad_len_ready",     byte_ready,       0);
        check("bad_len_busy",      busy,             0);
        check("bad_len_writes",    wr_addr_q.size(), 0);
    endtask

    initial begin
        int n;
        step();
        check_reset_outputs("por");
        step();
        reset_n = 1'b1;
        step();
        check_reset_outputs("idle");

        img_q = '{32'h005303b3, 32'h40848533, 32'h00160693};
        run_load(3, 1'b0, 1'b1);

        run_bad_len(8'h00);
        run_bad_len(8'h21);
        run_bad_len(8'($urandom_range(DEPTH + 1, 255)));

        img_q = '{32'h005303b3, 32'h40848533, 32'h00160693};
        run_load(3, 1'b1, 1'b0);

        rand_image(2);
        build_stream(2);
        pulse_start();
        clear_log();
        send_bytes(7, 1'b0, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        step();
        step();
        check("midload_we_held",  mem_we,           0);
        check("midload_writes",   wr_addr_q.size(), 1);
        ref_mem[0] = img_q[0];
        check("midload_word0",    obs_mem[0],       ref_mem[0]);
        reset_n = 1'b1;
        step();
        img_q = '{32'h00000513};
        run_load(1, 1'b0, 1'b0);

        rand_image(DEPTH);
        run_load(DEPTH, 1'b0, 1'b0);

        repeat (4) begin
            n = $urandom_range(1, DEPTH);
            rand_image(n);
            run_load(n, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        n = $urandom_range(1, DEPTH - 1);
        rand_image(n);
        build_stream(n);
        tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'($urandom_range(1, 255));
        pulse_start();
        clear_log();
        send_bytes(tx_q.size(), 1'b0, 1'b0);
        step();
        step();
        check("csum_bad_error",     error,            1);
        check("csum_bad_done",      done,             0);
        check("csum_bad_cpu_reset", cpu_reset,        1);
        check("csum_bad_writes",    wr_addr_q.size(), n);
        for (int i = 0; i < n; i++) ref_mem[i] = img_q[i];
        for (int i = 0; i < DEPTH; i++) check("csum_bad_mem", obs_mem[i], ref_mem[i]);
        run_load(n, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
